// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ADD/SUB/AND/ORR/LSL/LSR plus optional iterative MUL.
// Optional shift-add multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq_unit #(
   parameter int WIDTH = 64,
   parameter int SHW   = 6
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid,
   output logic             oReady,
   input  logic [10:0]      iOpcode,
   input  logic [1:0]       iALUOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oResult,
   output logic [3:0]       oFlags,
   output logic             oIllegal,
   output logic [1:0]       oDbgState
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR, OP_MUL, OP_ILL
   } op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       flags_q, flags_d;
   logic             illegal_q, illegal_d;

`ifdef ALU_SEQ_MUL_EN
   localparam int CNT_W = SHW + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

   op_e              op;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [3:0]       alu_flags;
   logic             accept, load;

   // Handshake: a request transfers on an edge where iValid && oReady; a result
   // transfers on an edge where oValid && iReady, and stays frozen until then.
   assign oReady    = (state_q == S_IDLE) || ((state_q == S_HOLD) && iReady);
   assign accept    = iValid && oReady;
   assign oValid    = (state_q == S_HOLD);
   assign oResult   = res_q;
   assign oFlags    = flags_q;
   assign oIllegal  = illegal_q;
   assign oDbgState = state_q;

   always_comb begin
      op = OP_ILL;
      case (iALUOp)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b10: begin
            if (iOpcode == 11'h69B) begin
               op = OP_LSL;
            end else if (iOpcode == 11'h69A) begin
               op = OP_LSR;
            end else if (iOpcode == 11'h4D8) begin
`ifdef ALU_SEQ_MUL_EN
               op = OP_MUL;
`else
               op = OP_ILL;
`endif
            end else begin
               case ({iOpcode[9:8], iOpcode[3]})
                  3'b001:  op = OP_ADD;
                  3'b101:  op = OP_SUB;
                  3'b000:  op = OP_AND;
                  3'b010:  op = OP_ORR;
                  default: op = OP_ILL;
               endcase
            end
         end
         default: op = OP_ILL;
      endcase
   end

   assign shamt = iB[SHW-1:0];
   assign sum   = {1'b0, iA} + {1'b0, iB};
   assign diff  = {1'b0, iA} - {1'b0, iB};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (iA[WIDTH-1] == iB[WIDTH-1]) && (alu_res[WIDTH-1] != iA[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = ~diff[WIDTH];
            alu_v   = (iA[WIDTH-1] != iB[WIDTH-1]) && (alu_res[WIDTH-1] != iA[WIDTH-1]);
         end
         OP_AND:  alu_res = iA & iB;
         OP_ORR:  alu_res = iA | iB;
         OP_LSL:  alu_res = iA << shamt;
         OP_LSR:  alu_res = iA >> shamt;
         default: alu_res = '0;
      endcase
      // Illegal ops report all-zero flags, not the Z that a zero result would imply.
      if (op == OP_ILL) begin
         alu_flags = 4'b0000;
      end else begin
         alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
      end
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      flags_d   = flags_q;
      illegal_d = illegal_q;
      load      = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
`endif
      case (state_q)
         S_IDLE: load = accept;
         S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
            if (cnt_q == '0) begin
               state_d   = S_HOLD;
               res_d     = acc_q;
               flags_d   = {acc_q[WIDTH-1], (acc_q == '0), 2'b00};
               illegal_d = 1'b0;
            end else begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - 1'b1;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_HOLD: begin
            if (iReady) begin
               if (iValid) load = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
`ifdef ALU_SEQ_MUL_EN
         if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = '0;
            mcand_d  = iA;
            mplier_d = iB;
         end else begin
            state_d   = S_HOLD;
            res_d     = alu_res;
            flags_d   = alu_flags;
            illegal_d = (op == OP_ILL);
         end
`else
         state_d   = S_HOLD;
         res_d     = alu_res;
         flags_d   = alu_flags;
         illegal_d = (op == OP_ILL);
`endif
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         res_q     <= '0;
         flags_q   <= 4'b0000;
         illegal_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
`ifdef ALU_SEQ_MUL_EN
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=64); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq_unit;

   localparam int W  = 64;
   localparam int SW = 6;

   logic         iCLK = 1'b0;
   logic         iRST;
   logic         iValid;
   logic         oReady;
   logic [10:0]  iOpcode;
   logic [1:0]   iALUOp;
   logic [W-1:0] iA, iB;
   logic         oValid;
   logic         iReady;
   logic [W-1:0] oResult;
   logic [3:0]   oFlags;
   logic         oIllegal;
   logic [1:0]   oDbgState;

   int n_vec = 0;
   int n_err = 0;

   alu_seq_unit #(.WIDTH(W), .SHW(SW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
      .iOpcode(iOpcode), .iALUOp(iALUOp), .iA(iA), .iB(iB),
      .oValid(oValid), .iReady(iReady), .oResult(oResult), .oFlags(oFlags),
      .oIllegal(oIllegal), .oDbgState(oDbgState)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [W-1:0] r,
                            input logic [3:0] f, input logic ill);
      check({tag, "_valid"},   W'(oValid),   W'(v));
      check({tag, "_result"},  oResult,      r);
      check({tag, "_flags"},   W'(oFlags),   W'(f));
      check({tag, "_illegal"}, W'(oIllegal), W'(ill));
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic set_op(input logic v, input logic [1:0] aluop, input logic [10:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      iValid  = v;
      iALUOp  = aluop;
      iOpcode = opc;
      iA      = a;
      iB      = b;
   endtask

   task automatic wait_valid(output int lat, output logic rdy_seen);
      lat      = 0;
      rdy_seen = 1'b0;
      while (!oValid && lat < 200) begin
         if (oReady) rdy_seen = 1'b1;
         step();
         lat++;
      end
   endtask

   int   lat;
   logic seen;

   initial begin
      iRST   = 1'b1;
      iReady = 1'b0;
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      step(); step();
      check_out("reset", 1'b0, '0, 4'b0000, 1'b0);
      check("reset_ready", W'(oReady), W'(1));
      iRST = 1'b0;
      step();
      check("ready_after_reset", W'(oReady), W'(1));

      // Signed overflow on ADD via field decode, held while iReady=0
      set_op(1'b1, 2'b10, 11'h458, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      set_op(1'b0, 2'b00, 11'h0, 64'd123, 64'd456);
      check_out("add_ovf", 1'b1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
      check("hold_ready_low", W'(oReady), W'(0));
      step(); step();
      check_out("add_ovf_hold", 1'b1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
      iReady = 1'b1;
      #1;
      check("hold_ready_follow", W'(oReady), W'(1));
      step();
      check("release_to_idle", W'(oValid), W'(0));

      set_op(1'b1, 2'b01, 11'h0, 64'd5, 64'd5);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("sub_eq", 1'b1, '0, 4'b0110, 1'b0);
      step();

      set_op(1'b1, 2'b00, 11'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("add_carry", 1'b1, '0, 4'b0110, 1'b0);
      step();

      set_op(1'b1, 2'b10, 11'h658, 64'd3, 64'd5);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("sub_borrow", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
      step();
      check("idle_after_sub", W'(oValid), W'(0));

      // Back-to-back single-cycle ops with the consumer always ready
      set_op(1'b1, 2'b10, 11'h550, 64'hF0, 64'h0F);
      step();
      set_op(1'b1, 2'b10, 11'h450, 64'hF0, 64'h3C);
      check_out("b2b_orr", 1'b1, 64'hFF, 4'b0000, 1'b0);
      step();
      set_op(1'b1, 2'b10, 11'h69B, 64'h1, 64'd4);
      check_out("b2b_and", 1'b1, 64'h30, 4'b0000, 1'b0);
      step();
      set_op(1'b1, 2'b10, 11'h69A, 64'h8000_0000_0000_0000, 64'd4);
      check_out("b2b_lsl", 1'b1, 64'h10, 4'b0000, 1'b0);
      step();
      set_op(1'b1, 2'b10, 11'h69B, 64'h1234, 64'd0);
      check_out("b2b_lsr", 1'b1, 64'h0800_0000_0000_0000, 4'b0000, 1'b0);
      step();
      set_op(1'b1, 2'b10, 11'h69A, 64'h1234, 64'd64);
      check_out("lsl_zero", 1'b1, 64'h1234, 4'b0000, 1'b0);
      step();
      set_op(1'b1, 2'b10, 11'h69B, 64'h1, 64'd65);
      check_out("lsr_amt_wraps", 1'b1, 64'h1234, 4'b0000, 1'b0);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("lsl_low_bits", 1'b1, 64'h2, 4'b0000, 1'b0);
      step();
      check("idle_after_b2b", W'(oValid), W'(0));

      iReady = 1'b0;
      set_op(1'b1, 2'b11, 11'h458, 64'd5, 64'd5);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("ill_aluop11", 1'b1, '0, 4'b0000, 1'b1);
      step(); step();
      check_out("ill_aluop11_hold", 1'b1, '0, 4'b0000, 1'b1);
      iReady = 1'b1;
      set_op(1'b1, 2'b10, 11'h558, 64'd1, 64'd1);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("ill_field", 1'b1, '0, 4'b0000, 1'b1);
      step();
      check("idle_after_ill", W'(oValid), W'(0));

      // Asynchronous reset while a result is held discards it
      iReady = 1'b0;
      set_op(1'b1, 2'b00, 11'h0, 64'd3, 64'd4);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("pre_rst_hold", 1'b1, 64'd7, 4'b0000, 1'b0);
      iRST = 1'b1;
      #1;
      check_out("rst_in_hold", 1'b0, '0, 4'b0000, 1'b0);
      iRST   = 1'b0;
      iReady = 1'b1;
      step();
      check("ready_after_hold_rst", W'(oReady), W'(1));

`ifdef ALU_SEQ_MUL_EN
      set_op(1'b1, 2'b10, 11'h4D8, 64'd12, 64'd10);
      step();
      set_op(1'b1, 2'b00, 11'h0, 64'd1, 64'd1);
      wait_valid(lat, seen);
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check("mul_latency", W'(lat), W'(W + 1));
      check("mul_busy_ready", W'(seen), W'(0));
      check_out("mul_12x10", 1'b1, 64'd120, 4'b0000, 1'b0);
      step();
      check("idle_after_mul", W'(oValid), W'(0));

      set_op(1'b1, 2'b10, 11'h4D8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      wait_valid(lat, seen);
      check("mul_wrap_latency", W'(lat), W'(W + 1));
      check_out("mul_wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
      step();

      set_op(1'b1, 2'b10, 11'h4D8, 64'd12, 64'd10);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      repeat (20) step();
      iRST = 1'b1;
      #1;
      check("mul_rst_valid", W'(oValid), W'(0));
      check("mul_rst_ready", W'(oReady), W'(1));
      iRST = 1'b0;
      seen = 1'b0;
      repeat (80) begin
         step();
         if (oValid) seen = 1'b1;
      end
      check("mul_rst_no_result", W'(seen), W'(0));
      set_op(1'b1, 2'b00, 11'h0, 64'd3, 64'd4);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("add_after_mul_rst", 1'b1, 64'd7, 4'b0000, 1'b0);
      step();
`else
      iReady = 1'b0;
      set_op(1'b1, 2'b10, 11'h4D8, 64'd12, 64'd10);
      step();
      set_op(1'b0, 2'b00, 11'h0, '0, '0);
      check_out("mul_disabled", 1'b1, '0, 4'b0000, 1'b1);
      step(); step();
      check_out("mul_disabled_hold", 1'b1, '0, 4'b0000, 1'b1);
      iReady = 1'b1;
      step();
      check("idle_after_mul_dis", W'(oValid), W'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the operand and result width in bits (legal: 8, 16, 32, 64).
REQ-002 The block SHALL take parameter SHW, default 6, as the shift-amount width, equal to log2(WIDTH).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 iCLK  in  1  clock; all state SHALL update on its rising edge.
REQ-005 iRST  in  1  asynchronous active-high reset.
REQ-006 iValid  in  1  operation request.
REQ-007 oReady  out  1  block can accept a request this cycle.
REQ-008 iOpcode  in  11  instruction opcode field [31:21].
REQ-009 iALUOp  in  2  ALU operation class from main control.
REQ-010 iA, iB  in  WIDTH  operands; the shift amount SHALL be iB[SHW-1:0].
REQ-011 oValid  out  1  result available.
REQ-012 iReady  in  1  consumer accepts the result.
REQ-013 oResult  out  WIDTH  result.
REQ-014 oFlags  out  4  {N,Z,C,V}.
REQ-015 oIllegal  out  1  the operation held in oResult did not decode.

Function
REQ-016 A request SHALL be accepted on a rising edge where iValid and oReady are both high; the opcode, ALUOp and operands SHALL be captured on that edge.
REQ-017 Decode: iALUOp 00 SHALL select ADD, 01 SHALL select SUB, and 11 SHALL be illegal.
REQ-018 For iALUOp 10, full-opcode matches SHALL take precedence: 11'h69B LSL, 11'h69A LSR, 11'h4D8 MUL.
REQ-019 Otherwise, for iALUOp 10, {iOpcode[9:8],iOpcode[3]} SHALL decode as 001 ADD, 101 SUB, 000 AND, 010 ORR; any other value SHALL be illegal.
REQ-020 An illegal operation SHALL give oResult=0, oFlags=0000 and oIllegal=1 with single-cycle latency.
REQ-021 The state machine SHALL have three states: IDLE, MUL, HOLD.
REQ-022 IDLE: an accepted non-MUL request SHALL go to HOLD, with the result registered and oValid=1 on the next edge (latency 1).
REQ-023 IDLE: an accepted MUL request SHALL go to MUL, load a shift-add counter with WIDTH, and clear the accumulator.
REQ-024 MUL: the block SHALL do one bit per cycle; at counter 0 it SHALL go to HOLD, for a latency of WIDTH+1 from acceptance.
REQ-025 MUL: the product SHALL be the low WIDTH bits, unsigned.
REQ-026 HOLD: oValid=1, and oResult, oFlags and oIllegal SHALL stay stable until iReady=1.
REQ-027 oReady SHALL be 1 in IDLE, 0 in MUL, and equal to iReady in HOLD.
REQ-028 HOLD with iReady=1 and an accepted request SHALL load the new operation on the same edge, so back-to-back single-cycle operations give one result per cycle.
REQ-029 HOLD with iReady=1 and no accepted request SHALL return to IDLE with oValid=0.
REQ-030 N SHALL equal result[WIDTH-1], and Z SHALL be 1 when result==0.
REQ-031 ADD: C SHALL be the carry out of bit WIDTH-1, and V SHALL be the signed overflow.
REQ-032 SUB (iA-iB): C SHALL be 1 when no borrow, and V SHALL be the signed overflow.
REQ-033 AND, ORR, LSL, LSR and MUL SHALL set C=0 and V=0.
REQ-034 Shifts SHALL be logical, with zero fill; a shift amount of 0 SHALL pass iA unchanged.
REQ-035 iValid while oReady=0 SHALL be ignored, and no input SHALL be captured.

Reset
REQ-036 iRST high SHALL immediately force IDLE, oValid=0, oResult=0, oFlags=0000 and oIllegal=0.
REQ-037 Reset SHALL clear the multiply counter and accumulator.
REQ-038 Reset during MUL or HOLD SHALL discard the operation in progress, and no result SHALL ever be presented for it.
REQ-039 oReady SHALL be 1 on the first edge after iRST deasserts.

Configuration
REQ-040 Macro ALU_SEQ_MUL_EN defined: MUL decode, the MUL state, the counter and the accumulator SHALL be present as specified above.
REQ-041 Macro ALU_SEQ_MUL_EN undefined: opcode 11'h4D8 with iALUOp 10 SHALL be illegal per REQ-020, the MUL state SHALL never be entered, and no multiplier logic SHALL be synthesised.

Verification
REQ-042 The bench SHALL cover: WIDTH=64, ALUOp 10, ADD opcode, iA=64'h7FFF_FFFF_FFFF_FFFF, iB=1 -> next cycle oValid=1, oResult=64'h8000_0000_0000_0000, NZCV=1001.
REQ-043 The bench SHALL cover: ALUOp 01, iA=5, iB=5 -> oResult=0, NZCV=0110.
REQ-044 The bench SHALL cover: ALU_SEQ_MUL_EN, MUL, iA=12, iB=10 -> oReady=0 for 64 cycles, oValid=1 on cycle 65, oResult=120, NZCV=0000.
REQ-045 The bench SHALL cover: iReady=1, four back-to-back ORR/AND/LSL(iB=4)/LSR requests -> four consecutive oValid cycles with correct results in order.
REQ-046 The bench SHALL cover: MUL accepted, iRST pulsed at cycle 20 -> oValid stays 0; a following ADD 3+4 -> oResult=7.
REQ-047 The bench SHALL cover: iALUOp=11, or ALU_SEQ_MUL_EN undefined with MUL -> 1 cycle latency, oIllegal=1, oResult=0, held while iReady=0.
